mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mc_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS-subset control unit.
// Moore state register plus instruction decode driving datapath controls.
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        ir_we,
  output logic        grf_we,
  output logic [1:0]  a3_sel,
  output logic [1:0]  wd_sel,
  output logic        alu_src,
  output logic [1:0]  ext_op,
  output logic [2:0]  alu_op,
  output logic        dm_we,
  output logic [2:0]  state,
  output logic        done,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_retired;

  logic w_rtype, w_addu, w_subu, w_jr;
  logic w_ori, w_lui, w_lw, w_sw;
  logic w_beq, w_j, w_jal, w_legal;

  assign w_rtype = (opcode == 6'h00);
  assign w_addu  = w_rtype && (funct == 6'h21);
  assign w_subu  = w_rtype && (funct == 6'h23);
  assign w_jr    = w_rtype && (funct == 6'h08);
  assign w_ori   = (opcode == 6'h0d);
  assign w_lui   = (opcode == 6'h0f);
  assign w_lw    = (opcode == 6'h23);
  assign w_sw    = (opcode == 6'h2b);
  assign w_beq   = (opcode == 6'h04);
  assign w_j     = (opcode == 6'h02);
  assign w_jal   = (opcode == 6'h03);
  assign w_legal = w_addu | w_subu | w_jr | w_ori | w_lui |
                   w_lw | w_sw | w_beq | w_j | w_jal;

  // Next state and per-state control outputs from state and decode.
  always_comb begin
    w_next  = S_FETCH;
    pc_we   = 1'b0;
    pc_sel  = 2'd0;
    ir_we   = 1'b0;
    grf_we  = 1'b0;
    a3_sel  = 2'd0;
    wd_sel  = 2'd0;
    alu_src = 1'b0;
    ext_op  = 2'd0;
    alu_op  = 3'd0;
    dm_we   = 1'b0;
    done    = 1'b0;
    case (r_state)
      S_FETCH: begin
        ir_we  = 1'b1;
        pc_we  = 1'b1;
        w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_legal) w_next = S_EXE;
        else         done   = 1'b1;
      end
      S_EXE: begin
        if (w_addu) begin
          w_next = S_WB;
        end else if (w_subu) begin
          alu_op = 3'd1;
          w_next = S_WB;
        end else if (w_ori || w_lui) begin
          alu_op  = 3'd2;
          alu_src = 1'b1;
          ext_op  = w_lui ? 2'd2 : 2'd0;
          w_next  = S_WB;
        end else if (w_lw || w_sw) begin
          alu_src = 1'b1;
          ext_op  = 2'd1;
          w_next  = S_MEM;
        end else if (w_beq) begin
          alu_op = 3'd1;
          pc_sel = 2'd1;
          pc_we  = zero;
          done   = 1'b1;
        end else if (w_j || w_jal) begin
          pc_we  = 1'b1;
          pc_sel = 2'd2;
          done   = 1'b1;
          if (w_jal) begin
            grf_we = 1'b1;
            a3_sel = 2'd2;
            wd_sel = 2'd2;
          end
        end else if (w_jr) begin
          pc_we  = 1'b1;
          pc_sel = 2'd3;
          done   = 1'b1;
        end
      end
      S_MEM: begin
        if (w_sw) begin
          dm_we = 1'b1;
          done  = 1'b1;
        end else if (w_lw) begin
          w_next = S_WB;
        end
      end
      S_WB: begin
        done = 1'b1;
        if (w_addu || w_subu) begin
          grf_we = 1'b1;
          a3_sel = 2'd1;
        end else if (w_ori || w_lui) begin
          grf_we = 1'b1;
        end else if (w_lw) begin
          grf_we = 1'b1;
          wd_sel = 2'd1;
        end
      end
      default: w_next = S_FETCH;
    endcase
    // Reset silences every enable at once, not just at the next edge.
    if (reset) begin
      pc_we  = 1'b0;
      ir_we  = 1'b0;
      grf_we = 1'b0;
      dm_we  = 1'b0;
      done   = 1'b0;
    end
  end

  // State register; reset parks the machine in FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Retired-instruction counter, wraps silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     r_retired <= 32'd0;
    else if (done) r_retired <= r_retired + 32'd1;
  end

  assign state   = r_state;
  assign retired = r_retired;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed + random instruction stream for mc_ctrl,
// checked against a per-instruction cycle-by-cycle expectation model.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        ir_we;
  logic        grf_we;
  logic [1:0]  a3_sel;
  logic [1:0]  wd_sel;
  logic        alu_src;
  logic [1:0]  ext_op;
  logic [2:0]  alu_op;
  logic        dm_we;
  logic [2:0]  state;
  logic        done;
  logic [31:0] retired;

  int errors = 0;
  int checks = 0;
  int unsigned model_retired = 0;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .zero(zero), .pc_we(pc_we), .pc_sel(pc_sel), .ir_we(ir_we),
    .grf_we(grf_we), .a3_sel(a3_sel), .wd_sel(wd_sel),
    .alu_src(alu_src), .ext_op(ext_op), .alu_op(alu_op),
    .dm_we(dm_we), .state(state), .done(done), .retired(retired)
  );

  always #5 clk = ~clk;

  // Instruction classes of the reference model.
  localparam int C_ADDU = 0, C_SUBU = 1, C_ORI = 2, C_LUI = 3;
  localparam int C_LW = 4, C_SW = 5, C_BEQ = 6, C_J = 7;
  localparam int C_JAL = 8, C_JR = 9, C_ILL = 10;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int classify(input logic [5:0] op,
                                  input logic [5:0] fn);
    if (op == 6'h00) begin
      if (fn == 6'h21) return C_ADDU;
      if (fn == 6'h23) return C_SUBU;
      if (fn == 6'h08) return C_JR;
      return C_ILL;
    end
    case (op)
      6'h0d: return C_ORI;
      6'h0f: return C_LUI;
      6'h23: return C_LW;
      6'h2b: return C_SW;
      6'h04: return C_BEQ;
      6'h02: return C_J;
      6'h03: return C_JAL;
      default: return C_ILL;
    endcase
  endfunction

  // Cycles each instruction spends from FETCH to its done cycle.
  function automatic int n_cycles(input int c);
    case (c)
      C_ILL: return 2;
      C_BEQ, C_J, C_JAL, C_JR: return 3;
      C_LW: return 5;
      default: return 4;
    endcase
  endfunction

  // Expected state visited in cycle k of an instruction.
  function automatic logic [2:0] exp_state(input int c, input int k);
    if (k < 3) return 3'(k);
    if (c == C_LW) return (k == 3) ? 3'd3 : 3'd4;
    if (c == C_SW) return 3'd3;
    return 3'd4;
  endfunction

  // Run one instruction from a FETCH-aligned negedge, checking every cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z);
    int c, n;
    bit last, jump, writes;
    c = classify(op, fn);
    n = n_cycles(c);
    jump   = (c == C_J) || (c == C_JAL) || (c == C_JR);
    writes = (c == C_ADDU) || (c == C_SUBU) || (c == C_ORI) ||
             (c == C_LUI) || (c == C_LW) || (c == C_JAL);
    opcode = op;
    funct  = fn;
    zero   = z;
    for (int k = 0; k < n; k++) begin
      #1;
      last = (k == n - 1);
      check($sformatf("state c%0d k%0d", c, k), 32'(state),
            32'(exp_state(c, k)));
      check($sformatf("done c%0d k%0d", c, k), 32'(done), 32'(last));
      check($sformatf("ir_we c%0d k%0d", c, k), 32'(ir_we), 32'(k == 0));
      check($sformatf("pc_we c%0d k%0d", c, k), 32'(pc_we),
            32'((k == 0) || (last && jump) ||
                (last && c == C_BEQ && z)));
      check($sformatf("grf_we c%0d k%0d", c, k), 32'(grf_we),
            32'(last && writes));
      check($sformatf("dm_we c%0d k%0d", c, k), 32'(dm_we),
            32'(last && c == C_SW));
      if (k == 0)
        check("pc_sel fetch", 32'(pc_sel), 32'd0);
      if (last && c == C_BEQ)
        check("pc_sel beq", 32'(pc_sel), 32'd1);
      if (last && (c == C_J || c == C_JAL))
        check("pc_sel j", 32'(pc_sel), 32'd2);
      if (last && c == C_JR)
        check("pc_sel jr", 32'(pc_sel), 32'd3);
      if (last && writes) begin
        check($sformatf("a3_sel c%0d", c), 32'(a3_sel),
              (c == C_JAL) ? 32'd2 :
              (c == C_ADDU || c == C_SUBU) ? 32'd1 : 32'd0);
        check($sformatf("wd_sel c%0d", c), 32'(wd_sel),
              (c == C_JAL) ? 32'd2 : (c == C_LW) ? 32'd1 : 32'd0);
      end
      if (k == 2 && c != C_J && c != C_JAL && c != C_JR) begin
        check($sformatf("alu_op c%0d", c), 32'(alu_op),
              (c == C_SUBU || c == C_BEQ) ? 32'd1 :
              (c == C_ORI || c == C_LUI) ? 32'd2 : 32'd0);
        check($sformatf("alu_src c%0d", c), 32'(alu_src),
              32'(c == C_ORI || c == C_LUI || c == C_LW || c == C_SW));
        if (c == C_ORI) check("ext_op ori", 32'(ext_op), 32'd0);
        if (c == C_LUI) check("ext_op lui", 32'(ext_op), 32'd2);
        if (c == C_LW || c == C_SW)
          check("ext_op mem", 32'(ext_op), 32'd1);
      end
      @(posedge clk);
      @(negedge clk);
    end
    model_retired++;
    #1;
    check($sformatf("retired after c%0d", c), retired, model_retired);
  endtask

  logic [5:0] ops [10];
  logic [5:0] fns [10];

  initial begin
    ops = '{6'h00, 6'h00, 6'h0d, 6'h0f, 6'h23,
            6'h2b, 6'h04, 6'h02, 6'h03, 6'h00};
    fns = '{6'h21, 6'h23, 6'h00, 6'h00, 6'h00,
            6'h00, 6'h00, 6'h00, 6'h00, 6'h08};
    opcode = 6'h00;
    funct  = 6'h00;
    zero   = 1'b0;
    reset  = 1'b1;
    #1;
    check("reset state", 32'(state), 32'd0);
    check("reset retired", retired, 32'd0);
    check("reset ir_we", 32'(ir_we), 32'd0);
    check("reset pc_we", 32'(pc_we), 32'd0);
    check("reset done", 32'(done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Directed sequence.
    run_instr(6'h00, 6'h21, 1'b0);
    run_instr(6'h23, 6'h00, 1'b0);
    run_instr(6'h2b, 6'h00, 1'b0);
    run_instr(6'h04, 6'h00, 1'b0);
    run_instr(6'h04, 6'h00, 1'b1);
    run_instr(6'h03, 6'h00, 1'b0);
    run_instr(6'h00, 6'h08, 1'b0);
    run_instr(6'h3f, 6'h00, 1'b0);
    run_instr(6'h00, 6'h00, 1'b0);
    run_instr(6'h0d, 6'h11, 1'b1);
    run_instr(6'h0f, 6'h3f, 1'b0);
    run_instr(6'h02, 6'h00, 1'b1);

    // Random stream: mostly legal, some arbitrary encodings.
    for (int i = 0; i < 150; i++) begin
      int sel;
      sel = $urandom_range(0, 12);
      if (sel < 10)
        run_instr(ops[sel], 6'($urandom), 1'($urandom));
      else
        run_instr(6'($urandom), 6'($urandom), 1'($urandom));
      if (sel < 10 && ops[sel] == 6'h00) begin
        run_instr(6'h00, fns[sel], 1'($urandom));
      end
    end

    // Asynchronous reset during lw MEM aborts the load.
    opcode = 6'h23;
    funct  = 6'h00;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    check("lw reached MEM", 32'(state), 32'd3);
    #1;
    reset = 1'b1;
    #1;
    check("async reset state", 32'(state), 32'd0);
    check("async reset retired", retired, 32'd0);
    check("async reset grf_we", 32'(grf_we), 32'd0);
    @(posedge clk);
    #1;
    check("held reset state", 32'(state), 32'd0);
    check("held reset grf_we", 32'(grf_we), 32'd0);
    check("held reset ir_we", 32'(ir_we), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_retired = 0;
    run_instr(6'h00, 6'h21, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
